// File: rtl/ts_gen_ml.sv
// Multi-lane TS1/TS2 ordered-set generator that broadcasts one template to all lanes in lockstep.
// Optional lane reversal input when TS_GEN_LANE_REV_EN is defined.
module ts_gen_ml #(
    parameter int          NUM_LANES    = 4,
    parameter int          CNT_W        = 16,
    parameter logic [7:0]  LINK_NUM     = 8'h01,
    parameter logic [5:0]  RATE_SUPPORT = 6'h02
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_ts_info,
    input  logic                     i_ts_update,
    output logic                     o_ts_update_ack,
    input  logic                     i_ts_stop,
    input  logic                     i_mode,
    input  logic [CNT_W-1:0]         i_ts_target,
    input  logic [7:0]               i_tsa_link_num,
    input  logic                     i_tsa_link_vld,
    output logic                     o_tsa_ack,
`ifdef TS_GEN_LANE_REV_EN
    input  logic                     i_lane_rev,
`endif
    output logic                     o_ts_valid,
    input  logic [NUM_LANES-1:0]     i_ts_ready,
    output logic [128*NUM_LANES-1:0] o_ts_data,
    output logic [CNT_W-1:0]         o_ts_cnt,
    output logic                     o_sent_enough
);

    // Symbol codes and LTSSM encodings: ts_info[7:4] 1=POLL, 2=CFG; i_mode 1=DSP, 0=USP.
    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] TS1_ID    = 8'h4A;
    localparam logic [7:0] TS2_ID    = 8'h45;
    localparam logic [3:0] ST_POLL   = 4'h1;
    localparam logic [3:0] ST_CFG    = 4'h2;
    localparam logic [3:0] POLL_CFG  = 4'h1;
    localparam logic [3:0] CFG_LW_ST = 4'h0;
    localparam logic [3:0] CFG_LW_AC = 4'h1;
    localparam logic [3:0] CFG_LN_WT = 4'h2;
    localparam logic [3:0] CFG_LN_AC = 4'h3;
    localparam logic [3:0] CFG_COMPL = 4'h4;
    localparam logic [3:0] CFG_IDLE  = 4'h5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TX} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_upd_armed;
    logic                       r_upd_ack;
    logic                       r_tsa_ack;
    logic [7:0]                 r_info;
    logic                       r_mode;
    logic [7:0]                 r_link_q;
    logic [CNT_W-1:0]           r_target;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_sent;
    logic [128*NUM_LANES-1:0]   r_data;
    logic [128*NUM_LANES-1:0]   w_data;
    logic                       w_upd_req;
    logic                       w_take;
    logic                       w_accept;
    logic                       w_rev;
    logic [7:0]                 w_link;
    logic [7:0]                 w_link_val;
    logic                       w_lane_pad;
    logic [7:0]                 w_id;

`ifdef TS_GEN_LANE_REV_EN
    logic r_lane_rev;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_lane_rev <= 1'b0;
        else if (w_take)
            r_lane_rev <= i_lane_rev;
    end
    assign w_rev = r_lane_rev;
`else
    assign w_rev = 1'b0;
`endif

    // A held ts_update is acked once; it must drop for a cycle before it can request again.
    assign w_upd_req = i_ts_update & r_upd_armed;
    assign w_take    = ((r_state == S_IDLE) || (r_state == S_TX)) &
                       (w_upd_req | i_tsa_link_vld) & ~i_ts_stop;
    assign w_accept  = (r_state == S_TX) & (&i_ts_ready);

    always_comb begin
        w_next = r_state;
        if (i_ts_stop)
            w_next = S_IDLE;
        else if (r_state == S_LOAD)
            w_next = S_TX;
        else if (w_take)
            w_next = S_LOAD;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_upd_armed <= 1'b1;
            r_upd_ack   <= 1'b0;
            r_tsa_ack   <= 1'b0;
            r_info      <= 8'h00;
            r_mode      <= 1'b0;
            r_link_q    <= PAD;
            r_target    <= '0;
            r_cnt       <= '0;
            r_sent      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_upd_ack <= w_take & w_upd_req;
            r_tsa_ack <= w_take & i_tsa_link_vld;
            if (w_take && w_upd_req)
                r_upd_armed <= 1'b0;
            else if (!i_ts_update)
                r_upd_armed <= 1'b1;
            if (w_take) begin
                r_info   <= i_ts_info;
                r_mode   <= i_mode;
                r_target <= i_ts_target;
                r_cnt    <= '0;
                r_sent   <= 1'b0;
                if (i_tsa_link_vld)
                    r_link_q <= i_tsa_link_num;
            end else if (r_state != S_IDLE) begin
                if (w_accept && !(&r_cnt))
                    r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt >= r_target)
                    r_sent <= 1'b1;
            end
            if (r_state == S_LOAD)
                r_data <= w_data;
        end
    end

    always_comb begin
        w_link     = PAD;
        w_lane_pad = 1'b1;
        w_id       = TS1_ID;
        w_link_val = r_mode ? LINK_NUM : r_link_q;
        case (r_info[7:4])
            ST_POLL: begin
                if (r_info[3:0] == POLL_CFG)
                    w_id = TS2_ID;
            end
            ST_CFG: begin
                case (r_info[3:0])
                    CFG_LW_ST: begin
                        if (r_mode)
                            w_link = LINK_NUM;
                    end
                    CFG_LW_AC: begin
                        w_link     = w_link_val;
                        w_lane_pad = ~r_mode;
                    end
                    CFG_LN_WT, CFG_LN_AC, CFG_IDLE: begin
                        w_link     = w_link_val;
                        w_lane_pad = 1'b0;
                    end
                    CFG_COMPL: begin
                        w_link     = w_link_val;
                        w_lane_pad = 1'b0;
                        w_id       = TS2_ID;
                    end
                    default: begin
                        w_link = PAD;
                    end
                endcase
            end
            default: begin
                w_link = PAD;
            end
        endcase
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_data[128*i +: 128] = {COM, w_link,
                                    w_lane_pad ? PAD : (w_rev ? 8'(NUM_LANES-1-i) : 8'(i)),
                                    8'hFF, {2'b00, RATE_SUPPORT}, 8'h00, {10{w_id}}};
        end
    end

    assign o_ts_valid      = (r_state == S_TX);
    assign o_ts_update_ack = r_upd_ack;
    assign o_tsa_ack       = r_tsa_ack;
    assign o_ts_data       = r_data;
    assign o_ts_cnt        = r_cnt;
    assign o_sent_enough   = r_sent;

endmodule

// File: tb/tb_ts_gen_ml.sv
// Self-checking bench for ts_gen_ml: directed scenarios plus randomized traffic against a behavioural model.
// Builds with or without TS_GEN_LANE_REV_EN.
module tb_ts_gen_ml;

    localparam int          NL   = 4;
    localparam int          CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;
    localparam logic [7:0]  LINK = 8'h01;
    localparam logic [5:0]  RATE = 6'h02;
    localparam logic [7:0]  COM  = 8'hBC;
    localparam logic [7:0]  PAD  = 8'hF7;
    localparam logic [7:0]  TS1  = 8'h4A;
    localparam logic [7:0]  TS2  = 8'h45;

    logic              clk;
    logic              rst;
    logic [7:0]        tsInfo;
    logic              tsUpdate;
    logic              tsUpdateAck;
    logic              tsStop;
    logic              mode;
    logic [CW-1:0]     tsTarget;
    logic [7:0]        tsaLinkNum;
    logic              tsaLinkVld;
    logic              tsaAck;
    logic              laneRev;
    logic              tsValid;
    logic [NL-1:0]     tsReady;
    logic [128*NL-1:0] tsData;
    logic [CW-1:0]     tsCnt;
    logic              sentEnough;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  mdlInfo;
    bit          mdlDsp;
    bit          mdlRev;
    logic [7:0]  mdlLinkq;
    int          mdlTarget;
    int          mdlCnt;
    bit          mdlSent;
    bit          mdlValid;

    ts_gen_ml #(.NUM_LANES(NL), .CNT_W(CW), .LINK_NUM(LINK), .RATE_SUPPORT(RATE)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ts_info(tsInfo),
        .i_ts_update(tsUpdate),
        .o_ts_update_ack(tsUpdateAck),
        .i_ts_stop(tsStop),
        .i_mode(mode),
        .i_ts_target(tsTarget),
        .i_tsa_link_num(tsaLinkNum),
        .i_tsa_link_vld(tsaLinkVld),
        .o_tsa_ack(tsaAck),
`ifdef TS_GEN_LANE_REV_EN
        .i_lane_rev(laneRev),
`endif
        .o_ts_valid(tsValid),
        .i_ts_ready(tsReady),
        .o_ts_data(tsData),
        .o_ts_cnt(tsCnt),
        .o_sent_enough(sentEnough)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dutSym(input int lane, input int sym);
        return tsData[128*lane + 127 - 8*sym -: 8];
    endfunction

    // Expected ordered set for one lane, assembled symbol by symbol from the LTSSM rules.
    function automatic logic [127:0] expTs(input int lane);
        logic [7:0]   s [16];
        logic [127:0] r;
        logic [7:0]   linkVal;
        logic [7:0]   laneVal;
        bit           isPoll;
        bit           isCfg;
        int           sub;
        bit           ts2;
        isPoll  = (mdlInfo[7:4] == 4'h1);
        isCfg   = (mdlInfo[7:4] == 4'h2);
        sub     = int'(mdlInfo[3:0]);
        linkVal = mdlDsp ? LINK : mdlLinkq;
        laneVal = mdlRev ? 8'(NL - 1 - lane) : 8'(lane);
        ts2     = (isPoll && sub == 1) || (isCfg && sub == 4);
        s[0] = COM;
        s[1] = PAD;
        s[2] = PAD;
        s[3] = 8'hFF;
        s[4] = {2'b00, RATE};
        s[5] = 8'h00;
        if (isCfg && sub == 0 && mdlDsp)
            s[1] = LINK;
        if (isCfg && sub == 1) begin
            s[1] = linkVal;
            if (mdlDsp)
                s[2] = laneVal;
        end
        if (isCfg && sub >= 2 && sub <= 5) begin
            s[1] = linkVal;
            s[2] = laneVal;
        end
        for (int j = 6; j < 16; j++)
            s[j] = ts2 ? TS2 : TS1;
        for (int j = 0; j < 16; j++)
            r[127 - 8*j -: 8] = s[j];
        return r;
    endfunction

    task automatic checkAll;
        checkOutput("valid", tsValid, mdlValid);
        checkOutput("cnt", tsCnt, mdlCnt);
        checkOutput("sentEnough", sentEnough, mdlSent);
        checkOutput("updAckIdle", tsUpdateAck, 1'b0);
        checkOutput("tsaAckIdle", tsaAck, 1'b0);
        if (mdlValid)
            for (int i = 0; i < NL; i++)
                checkOutput($sformatf("data%0d", i), tsData[128*i +: 128], expTs(i));
    endtask

    task automatic applyStimulus(input int n, input bit rnd, input logic [NL-1:0] pat);
        bit acc;
        int cntBefore;
        for (int k = 0; k < n; k++) begin
            tsReady   = rnd ? (($urandom_range(0, 2) == 0) ? NL'($urandom) : '1) : pat;
            acc       = mdlValid && (&tsReady);
            cntBefore = mdlCnt;
            tick();
            if (acc && mdlCnt < MAXC)
                mdlCnt++;
            if (mdlValid && cntBefore >= mdlTarget)
                mdlSent = 1'b1;
            checkAll();
        end
    endtask

    task automatic doUpdate(input logic [7:0] info, input bit dsp, input int target,
                            input bit upd, input bit tsa, input logic [7:0] link, input bit hold);
        tsInfo     = info;
        mode       = dsp;
        tsTarget   = CW'(target);
        tsUpdate   = upd;
        tsaLinkVld = tsa;
        tsaLinkNum = link;
        tsReady    = '1;
        tick();
        checkOutput("updAck", tsUpdateAck, upd);
        checkOutput("tsaAck", tsaAck, tsa);
        checkOutput("validLoad", tsValid, 1'b0);
        checkOutput("cntClr", tsCnt, '0);
        checkOutput("sentClr", sentEnough, 1'b0);
        mdlInfo   = info;
        mdlDsp    = dsp;
        mdlRev    = laneRev;
        mdlTarget = target;
        mdlCnt    = 0;
        mdlSent   = 1'b0;
        mdlValid  = 1'b0;
        if (tsa)
            mdlLinkq = link;
        if (!hold)
            tsUpdate = 1'b0;
        tsaLinkVld = 1'b0;
        tick();
        mdlValid = 1'b1;
        mdlSent  = (0 >= target);
        checkAll();
    endtask

    initial begin
        rst = 1'b1; tsInfo = '0; tsUpdate = 0; tsStop = 0; mode = 0; tsTarget = '0;
        tsaLinkNum = '0; tsaLinkVld = 0; laneRev = 0; tsReady = '0;
        mdlInfo = '0; mdlDsp = 0; mdlRev = 0; mdlLinkq = PAD; mdlTarget = 0;
        mdlCnt = 0; mdlSent = 0; mdlValid = 0;
        tick();
        tick();
        checkOutput("rstValid", tsValid, 1'b0);
        checkOutput("rstUpdAck", tsUpdateAck, 1'b0);
        checkOutput("rstTsaAck", tsaAck, 1'b0);
        checkOutput("rstCnt", tsCnt, '0);
        checkOutput("rstSent", sentEnough, 1'b0);
        for (int i = 0; i < NL; i++)
            checkOutput("rstData", tsData[128*i +: 128], '0);
        rst = 1'b0;
        applyStimulus(2, 1'b0, '1);

        doUpdate(8'h10, 1'b1, 4, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("pollSym1", dutSym(2, 1), PAD);
        checkOutput("pollSym2", dutSym(2, 2), PAD);
        checkOutput("pollSym6", dutSym(0, 6), TS1);
        applyStimulus(7, 1'b0, '1);

        doUpdate(8'h21, 1'b1, 9, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NL; i++) begin
            checkOutput("lwAccSym1", dutSym(i, 1), 8'h01);
            checkOutput("lwAccSym2", dutSym(i, 2), 8'(i));
        end
        applyStimulus(4, 1'b0, '1);
        applyStimulus(5, 1'b0, 4'b1011);
        applyStimulus(4, 1'b0, '1);

        doUpdate(8'h24, 1'b1, 3, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("complSym6", dutSym(1, 6), TS2);
        checkOutput("complSym15", dutSym(3, 15), TS2);
        applyStimulus(6, 1'b1, '1);

        doUpdate(8'h21, 1'b0, 10, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(3, 1'b0, '1);
        doUpdate(8'h21, 1'b0, 10, 1'b0, 1'b1, 8'h07, 1'b0);
        for (int i = 0; i < NL; i++) begin
            checkOutput("uspSym1", dutSym(i, 1), 8'h07);
            checkOutput("uspSym2", dutSym(i, 2), PAD);
        end
        applyStimulus(3, 1'b0, '1);

        doUpdate(8'h23, 1'b0, 2, 1'b1, 1'b1, 8'h2C, 1'b0);
        checkOutput("bothSym1", dutSym(3, 1), 8'h2C);
        applyStimulus(4, 1'b1, '1);

        doUpdate(8'h7A, 1'b1, 5, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, '1);
        doUpdate(8'h29, 1'b1, 5, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, '1);

        doUpdate(8'h22, 1'b1, 0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("tgt0Sent", sentEnough, 1'b1);
        applyStimulus(2, 1'b0, '1);

        doUpdate(8'h25, 1'b1, 12, 1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(8, 1'b0, '1);
        tsUpdate = 1'b0;
        applyStimulus(1, 1'b0, '1);

        doUpdate(8'h11, 1'b1, 15, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(20, 1'b0, '1);

        // Stop and update in the same cycle: the accepted beat counts, the update is dropped.
        doUpdate(8'h10, 1'b1, 14, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, '1);
        tsStop   = 1'b1;
        tsUpdate = 1'b1;
        tsReady  = '1;
        tick();
        if (mdlCnt < MAXC)
            mdlCnt++;
        mdlValid = 1'b0;
        checkAll();
        tsStop   = 1'b0;
        tsUpdate = 1'b0;
        applyStimulus(3, 1'b1, '1);

        doUpdate(8'h21, 1'b1, 6, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, '1);
        tsStop  = 1'b1;
        tsReady = 4'b0111;
        tick();
        mdlValid = 1'b0;
        checkAll();
        tsStop = 1'b0;
        applyStimulus(2, 1'b0, '1);

        for (int it = 0; it < 8; it++) begin
            logic [7:0] infos [11];
            bit         u;
            bit         t;
            infos = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h35};
            u = 1'($urandom);
            t = u ? 1'($urandom) : 1'b1;
            doUpdate(infos[$urandom_range(0, 10)], 1'($urandom), $urandom_range(0, 9),
                     u, t, 8'($urandom), 1'b0);
            applyStimulus(10, 1'b1, '1);
        end

`ifdef TS_GEN_LANE_REV_EN
        laneRev = 1'b1;
        doUpdate(8'h23, 1'b1, 4, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NL; i++)
            checkOutput("revSym2", dutSym(i, 2), 8'(NL - 1 - i));
        applyStimulus(2, 1'b0, '1);
        laneRev = 1'b0;
`endif

        doUpdate(8'h22, 1'b1, 3, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, '1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncValid", tsValid, 1'b0);
        checkOutput("asyncCnt", tsCnt, '0);
        checkOutput("asyncData", tsData[127:0], '0);
        #1 rst = 1'b0;
        mdlValid = 1'b0; mdlCnt = 0; mdlSent = 1'b0; mdlLinkq = PAD;
        applyStimulus(2, 1'b0, '1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
